// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: time-multiplexed sequencer for the 7-tap, 3-input polyphase
// FIR section. One shared 12x11 multiplier and one accumulator walk the seven taps
// once per sample period. The block also produces the sample-rate enable and holds
// a double-buffered (shadow/active) runtime coefficient bank.
module fir_mac_scheduler #(
    parameter int SAMPLE_DIV = 9,   // clk cycles per sample period, >= 9
    parameter int ACC_W      = 26   // accumulator width (sfix26_En14), >= 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic signed [10:0]  in1,
    input  logic signed [10:0]  in2,
    input  logic signed [10:0]  in3,
    input  logic                coef_we,
    input  logic [2:0]          coef_addr,
    input  logic signed [11:0]  coef_wdata,
    input  logic                coef_commit,
    output logic                sample_enb,
    output logic signed [21:0]  y,
    output logic                y_valid,
    output logic                sat_flag,
    output logic                busy
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    // Output clip limits expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(2097151);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-2097152);

    logic [CNT_W-1:0]         cnt_reg;
    logic                     run_q;
    logic [1:0]               state_reg;
    logic [2:0]               tap_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     pending_reg;

    logic signed [10:0]       d0_reg [1:5];
    logic signed [10:0]       d1_reg [1:4];
    logic signed [10:0]       d2_reg [1:3];

    logic signed [11:0]       shadow_reg [0:6];
    logic signed [11:0]       active_reg [0:6];

    logic                     frame_start;
    logic                     copy_now;
    logic signed [11:0]       tap_coef;
    logic signed [10:0]       tap_data;
    logic signed [22:0]       product;
    logic                     over_hi;
    logic                     over_lo;
    logic signed [21:0]       y_next;

    assign sample_enb  = run_q & (cnt_reg == '0);
    assign busy        = (state_reg != ST_IDLE);
    // With SAMPLE_DIV >= 9 the FSM is always back in IDLE when sample_enb fires.
    assign frame_start = sample_enb & (state_reg == ST_IDLE);
    // The shadow->active copy is only allowed between frames, including the start edge.
    assign copy_now    = pending_reg & (state_reg == ST_IDLE);

    // Sample-period counter; parks at 0 while run is low so a period always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= run;
            if (cnt_reg == '0 && !run_q)
                cnt_reg <= '0;
            else if (cnt_reg == CNT_W'(SAMPLE_DIV - 1))
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Polyphase delay lines advance once per sample period; index 1 is the newest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= 5; k++) d0_reg[k] <= '0;
            for (int k = 1; k <= 4; k++) d1_reg[k] <= '0;
            for (int k = 1; k <= 3; k++) d2_reg[k] <= '0;
        end else if (frame_start) begin
            d0_reg[1] <= in1;
            d1_reg[1] <= in2;
            d2_reg[1] <= in3;
            for (int k = 2; k <= 5; k++) d0_reg[k] <= d0_reg[k-1];
            for (int k = 2; k <= 4; k++) d1_reg[k] <= d1_reg[k-1];
            for (int k = 2; k <= 3; k++) d2_reg[k] <= d2_reg[k-1];
        end
    end

    // Commit request is remembered until the FSM is idle; repeated commits merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending_reg <= 1'b0;
        else if (copy_now)
            pending_reg <= 1'b0;
        else if (coef_commit)
            pending_reg <= 1'b1;
    end

    // Coefficient bank: shadow takes writes any time, active only changes between frames.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_coef
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    shadow_reg[gi] <= '0;
                else if (coef_we && coef_addr == 3'(gi))
                    shadow_reg[gi] <= coef_wdata;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    active_reg[gi] <= '0;
                else if (copy_now)
                    active_reg[gi] <= shadow_reg[gi];
            end
        end
    endgenerate

    // Tap operand selection: which coefficient pairs with which delay-line slot.
    always_comb begin
        tap_coef = '0;
        tap_data = '0;
        case (tap_reg)
            3'd0: begin tap_coef = active_reg[0]; tap_data = d0_reg[1]; end
            3'd1: begin tap_coef = active_reg[1]; tap_data = d2_reg[1]; end
            3'd2: begin tap_coef = active_reg[2]; tap_data = d1_reg[2]; end
            3'd3: begin tap_coef = active_reg[3]; tap_data = d0_reg[3]; end
            3'd4: begin tap_coef = active_reg[4]; tap_data = d2_reg[3]; end
            3'd5: begin tap_coef = active_reg[5]; tap_data = d1_reg[4]; end
            3'd6: begin tap_coef = active_reg[6]; tap_data = d0_reg[5]; end
            default: begin tap_coef = '0; tap_data = '0; end
        endcase
    end

    // Full-precision sfix23_En14 product; operands sign-extended before multiply.
    assign product = 23'(tap_coef) * 23'(tap_data);

    // Saturate the accumulator into the 22-bit output range.
    always_comb begin
        over_hi = (acc_reg > ACC_MAX);
        over_lo = (acc_reg < ACC_MIN);
        if (over_hi)
            y_next = 22'sh1FFFFF;
        else if (over_lo)
            y_next = 22'sh200000;
        else
            y_next = acc_reg[21:0];
    end

    // Frame FSM: IDLE waits for the sample edge, MAC runs seven taps, OUT publishes y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            tap_reg   <= '0;
            acc_reg   <= '0;
            y         <= '0;
            y_valid   <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            y_valid  <= 1'b0;
            sat_flag <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (frame_start) begin
                        acc_reg   <= '0;
                        tap_reg   <= '0;
                        state_reg <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_reg <= acc_reg + ACC_W'(product);
                    tap_reg <= tap_reg + 3'd1;
                    if (tap_reg == 3'd6)
                        state_reg <= ST_OUT;
                end
                ST_OUT: begin
                    y         <= y_next;
                    y_valid   <= 1'b1;
                    sat_flag  <= over_hi | over_lo;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: table of per-frame input samples with hand-computed
// outputs, plus directed sequences for mid-frame commit, run drop and reset abort.
module tb_fir_mac_scheduler;

    logic               clk = 1'b0;
    logic               reset;
    logic               run;
    logic signed [10:0] in1, in2, in3;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [11:0] coef_wdata;
    logic               coef_commit;
    logic               sample_enb;
    logic signed [21:0] y;
    logic               y_valid;
    logic               sat_flag;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int a;
        int b;
        int c;
        int exp_y;
        int exp_sat;
    } vec_t;

    vec_t vecs [19];

    fir_mac_scheduler #(.SAMPLE_DIV(9), .ACC_W(26)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .sample_enb  (sample_enb),
        .y           (y),
        .y_valid     (y_valid),
        .sat_flag    (sat_flag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0;
        in1 = '0; in2 = '0; in3 = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; coef_commit = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [11:0] v);
        coef_we = 1'b1; coef_addr = a; coef_wdata = v;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic do_commit();
        coef_commit = 1'b1;
        @(negedge clk);
        coef_commit = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_all(input logic [11:0] v);
        for (int k = 0; k < 7; k++) write_coef(3'(k), v);
    endtask

    // Waits for a sample_enb cycle, presents the samples, then waits for y_valid.
    // Called and returns at a negedge.
    task automatic next_frame(input int a, input int b, input int c,
                              output longint yo, output longint so, output int lat);
        int n;
        n = 0;
        while (!sample_enb && n < 20) begin @(negedge clk); n++; end
        in1 = 11'(a); in2 = 11'(b); in3 = 11'(c);
        @(negedge clk);
        check("yv_pulse_clear", y_valid, 0);
        lat = 0;
        while (!y_valid && lat < 20) begin @(negedge clk); lat++; end
        yo = y;
        so = sat_flag;
    endtask

    task automatic run_section(input int lo, input int hi);
        longint yo, so;
        int     lat;
        for (int i = lo; i <= hi; i++) begin
            next_frame(vecs[i].a, vecs[i].b, vecs[i].c, yo, so, lat);
            check($sformatf("vec%0d_y", i), yo, vecs[i].exp_y);
            check($sformatf("vec%0d_sat", i), so, vecs[i].exp_sat);
            check($sformatf("vec%0d_lat", i), lat, 8);
        end
    endtask

    initial begin
        longint yo, so;
        int     lat, ev;

        // Impulse with all coefs 0.5: tap0, tap3, tap6 see in1 on frames 1, 3, 5.
        vecs[0]  = '{8, 0, 0, 8192, 0};
        vecs[1]  = '{0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 8192, 0};
        vecs[3]  = '{0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 8192, 0};
        vecs[5]  = '{0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0};
        // Coefs raw 1..7: y = a[n]+2c[n]+3b[n-1]+4a[n-2]+5c[n-2]+6b[n-3]+7a[n-4].
        vecs[7]  = '{1, 2, 3, 7, 0};
        vecs[8]  = '{-1, 0, 4, 13, 0};
        vecs[9]  = '{10, -5, 0, 29, 0};
        vecs[10] = '{0, 0, 0, 13, 0};
        vecs[11] = '{0, 0, 0, 47, 0};
        vecs[12] = '{-1024, -1024, -1024, -3109, 0};
        vecs[13] = '{0, 0, 0, -3002, 0};
        // Coefs 0x7FF, extreme inputs: clip both ways.
        vecs[14] = '{-1024, -1024, -1024, -2097152, 1};
        vecs[15] = '{-1024, -1024, -1024, -2097152, 1};
        vecs[16] = '{-1024, -1024, -1024, -2097152, 1};
        vecs[17] = '{1023, 1023, 1023, 2097151, 1};
        vecs[18] = '{1023, 1023, 1023, 2097151, 1};

        // Reset state and idle hold with run low.
        do_reset();
        check("rst_y", y, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_sample_enb", sample_enb, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat_flag, 0);
        ev = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sample_enb || busy || y_valid) ev++;
        end
        check("idle_50_events", ev, 0);

        // Impulse response.
        load_all(12'h400); do_commit();
        run = 1'b1;
        run_section(0, 6);

        // Distinct coefficients, mixed inputs.
        do_reset();
        for (int k = 0; k < 7; k++) write_coef(3'(k), 12'(k + 1));
        do_commit();
        run = 1'b1;
        run_section(7, 13);

        // Saturation, negative then positive.
        do_reset();
        load_all(12'h7FF); do_commit();
        run = 1'b1;
        run_section(14, 16);
        do_reset();
        load_all(12'h7FF); do_commit();
        run = 1'b1;
        run_section(17, 18);

        // Commit during tap 3: current frame keeps old coefs, next one uses new.
        do_reset();
        load_all(12'h400); do_commit();
        load_all(12'h200);
        run = 1'b1;
        next_frame(8, 0, 0, yo, so, lat); check("cm_f1", yo, 8192);
        next_frame(8, 0, 0, yo, so, lat); check("cm_f2", yo, 8192);
        next_frame(8, 0, 0, yo, so, lat); check("cm_f3", yo, 16384);
        next_frame(8, 0, 0, yo, so, lat); check("cm_f4", yo, 16384);
        next_frame(8, 0, 0, yo, so, lat); check("cm_f5", yo, 24576);
        check("cm_se_at_f6", sample_enb, 1);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("cm_busy_mac", busy, 1);
        coef_commit = 1'b1;
        @(negedge clk);
        coef_commit = 1'b0;
        lat = 0;
        while (!y_valid && lat < 20) begin @(negedge clk); lat++; end
        check("cm_old_coefs", y, 24576);
        next_frame(8, 0, 0, yo, so, lat); check("cm_new_coefs", yo, 12288);

        // Run dropped at cnt=2: frame completes, then everything parks.
        check("rd_se_at_start", sample_enb, 1);
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        lat = 0;
        while (!y_valid && lat < 20) begin @(negedge clk); lat++; end
        check("rd_y", y, 12288);
        check("rd_lat", lat, 7);
        ev = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sample_enb || y_valid) ev++;
        end
        check("rd_no_events", ev, 0);
        check("rd_busy", busy, 0);
        check("rd_y_hold", y, 12288);

        // Reset pulse at cnt=4 aborts the frame; then impulse test repeats exactly.
        run = 1'b1;
        lat = 0;
        while (!sample_enb && lat < 20) begin @(negedge clk); lat++; end
        repeat (4) @(negedge clk);
        check("ra_busy_before", busy, 1);
        reset = 1'b1;
        run = 1'b0;
        #1;
        check("ra_y", y, 0);
        check("ra_busy", busy, 0);
        check("ra_y_valid", y_valid, 0);
        check("ra_sample_enb", sample_enb, 0);
        check("ra_sat", sat_flag, 0);
        @(negedge clk);
        reset = 1'b0;
        ev = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (y_valid || busy) ev++;
        end
        check("ra_no_frame", ev, 0);
        in1 = '0; in2 = '0; in3 = '0;
        load_all(12'h400); do_commit();
        run = 1'b1;
        run_section(0, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
